// File: rtl/imem_responder_if.sv
// Fetch-side handshake between the core (master) and imem_responder (slave).
interface imem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: loader-filled word store, one outstanding fetch, fixed LATENCY.
// Define IMEM_BOUNDS_CHECK_EN to answer out-of-range fetches with ebreak and resp_err=1.
module imem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data,
    imem_responder_if.slave       bus
);
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [31:0] store [DEPTH];

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] resp_data_q;
    logic        resp_err_q;
    logic        accept;
    logic [31:0] fetch_data;
    logic        fetch_err;

    // Store is deliberately not reset; loads are legal in every state.
    always_ff @(posedge clk) begin
        if (load_en) begin
            store[load_addr] <= load_data;
        end
    end

    // A same-cycle load blocks acceptance, so a fetch never reads a word being written.
    assign bus.req_ready = rst && !load_en && (state == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;

`ifdef IMEM_BOUNDS_CHECK_EN
    logic in_range;
    assign in_range = (bus.req_addr[31:DEPTH_LOG2] == '0);

    always_comb begin
        fetch_data = EBREAK;
        fetch_err  = 1'b1;
        if (in_range) begin
            fetch_data = store[bus.req_addr[DEPTH_LOG2-1:0]];
            fetch_err  = 1'b0;
        end
    end
`else
    logic unused_addr_hi;
    assign unused_addr_hi = |bus.req_addr[31:DEPTH_LOG2];

    always_comb begin
        fetch_data = store[bus.req_addr[DEPTH_LOG2-1:0]];
        fetch_err  = 1'b0;
    end
`endif

    // WAIT lasts LATENCY-1 cycles, so RESP appears LATENCY cycles after the accept cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        resp_data_q <= fetch_data;
                        resp_err_q  <= fetch_err;
                        cnt         <= LAT_M1;
                        state       <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.resp_valid = (state == RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: three instances (LATENCY 1, 2, 4), directed vectors.
module tb_imem_responder;
    localparam int NDUT = 3;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    bit          seen [NDUT];

    logic        rst_v        [NDUT];
    logic        load_en_v    [NDUT];
    logic [9:0]  load_addr_v  [NDUT];
    logic [31:0] load_data_v  [NDUT];
    logic        req_valid_v  [NDUT];
    logic [31:0] req_addr_v   [NDUT];
    logic        resp_ready_v [NDUT];
    logic        req_ready_v  [NDUT];
    logic        resp_valid_v [NDUT];
    logic [31:0] resp_data_v  [NDUT];
    logic        resp_err_v   [NDUT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        imem_responder_if bus ();
        assign bus.req_valid    = req_valid_v[g];
        assign bus.req_addr     = req_addr_v[g];
        assign bus.resp_ready   = resp_ready_v[g];
        assign req_ready_v[g]   = bus.req_ready;
        assign resp_valid_v[g]  = bus.resp_valid;
        assign resp_data_v[g]   = bus.resp_data;
        assign resp_err_v[g]    = bus.resp_err;

        imem_responder #(.DEPTH_LOG2(10), .LATENCY(lat_of(g))) u_dut (
            .clk       (clk),
            .rst       (rst_v[g]),
            .load_en   (load_en_v[g]),
            .load_addr (load_addr_v[g]),
            .load_data (load_data_v[g]),
            .bus       (bus)
        );
    end

    function automatic void check(input string name, input int d,
                                  input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d: got %h, required %h", name, d, act, req);
        end
    endfunction

    function automatic void fail_timeout(input string name, input int d);
        checks++;
        errors++;
        $display("FAIL %s dut%0d: timed out, required completion within bound", name, d);
    endfunction

    // Monitor: compares every presented response against the head of the scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (resp_valid_v[d] === 1'b1) begin
                if (exp_q.size() == 0 || exp_q[0].dut != d) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp dut%0d: got resp_valid=1 data=%h, required no response",
                             d, resp_data_v[d]);
                end else begin
                    if (!seen[d]) begin
                        check("latency", d, 32'(cyc - exp_q[0].acc), 32'(lat_of(d)));
                        seen[d] = 1'b1;
                    end
                    check("resp_data", d, resp_data_v[d], exp_q[0].data);
                    check("resp_err", d, 32'(resp_err_v[d]), 32'(exp_q[0].err));
                    if (resp_ready_v[d] === 1'b1) begin
                        void'(exp_q.pop_front());
                        seen[d] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int d, input logic [9:0] a, input logic [31:0] v);
        load_en_v[d]   = 1'b1;
        load_addr_v[d] = a;
        load_data_v[d] = v;
        step();
        load_en_v[d]   = 1'b0;
    endtask

    // Returns just after the accepting edge; req_addr is then scrambled.
    task automatic issue(input int d, input logic [31:0] addr, input logic [31:0] ed,
                         input logic ee, input bit push);
        int n = 0;
        req_addr_v[d]  = addr;
        req_valid_v[d] = 1'b1;
        @(negedge clk);
        while (req_ready_v[d] !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (req_ready_v[d] !== 1'b1) begin
            fail_timeout("accept", d);
        end else if (push) begin
            exp_q.push_back('{d, ed, ee, cyc});
        end
        step();
        req_valid_v[d] = 1'b0;
        req_addr_v[d]  = 32'hDEAD_BEEF;
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            fail_timeout("response", d);
            exp_q.delete();
        end
        step();
    endtask

    task automatic wait_valid(input int d);
        int n = 0;
        @(negedge clk);
        while (resp_valid_v[d] !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (resp_valid_v[d] !== 1'b1) fail_timeout("wait_valid", d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst_v[d]        = 1'b0;
            load_en_v[d]    = 1'b0;
            load_addr_v[d]  = '0;
            load_data_v[d]  = '0;
            req_valid_v[d]  = 1'b1;
            req_addr_v[d]   = 32'd5;
            resp_ready_v[d] = 1'b1;
            seen[d]         = 1'b0;
        end

        // Reset held 3 cycles with a fetch presented.
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                check("rst_req_ready", d, 32'(req_ready_v[d]), 32'd0);
                check("rst_resp_valid", d, 32'(resp_valid_v[d]), 32'd0);
                check("rst_resp_data", d, resp_data_v[d], 32'h0);
                check("rst_resp_err", d, 32'(resp_err_v[d]), 32'd0);
            end
        end
        step();
        for (int d = 0; d < NDUT; d++) begin
            rst_v[d]       = 1'b1;
            req_valid_v[d] = 1'b0;
        end
        step();

        // Basic fetch on each latency.
        load(1, 10'd5, 32'h0050_0093);
        issue(1, 32'd5, 32'h0050_0093, 1'b0, 1);
        wait_idle(1);
        load(0, 10'd1, 32'h0010_0093);
        issue(0, 32'd1, 32'h0010_0093, 1'b0, 1);
        wait_idle(0);
        load(2, 10'd3, 32'h0030_0113);
        issue(2, 32'd3, 32'h0030_0113, 1'b0, 1);
        wait_idle(2);

        // Backpressure: hold resp_ready low for 4 RESP cycles.
        resp_ready_v[1] = 1'b0;
        load(1, 10'd9, 32'h0090_0113);
        issue(1, 32'd9, 32'h0090_0113, 1'b0, 1);
        wait_valid(1);
        for (int k = 0; k < 4; k++) begin
            check("bp_resp_valid", 1, 32'(resp_valid_v[1]), 32'd1);
            check("bp_req_ready", 1, 32'(req_ready_v[1]), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        resp_ready_v[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_req_ready", 1, 32'(req_ready_v[1]), 32'd1);
        check("bp_release_resp_valid", 1, 32'(resp_valid_v[1]), 32'd0);
        step();

        // Load during WAIT does not disturb the captured word.
        load(2, 10'd7, 32'hAAAA_0013);
        issue(2, 32'd7, 32'hAAAA_0013, 1'b0, 1);
        load(2, 10'd7, 32'h1111_0013);
        wait_idle(2);
        issue(2, 32'd7, 32'h1111_0013, 1'b0, 1);
        wait_idle(2);

        // Load and request in the same cycle: request must not be accepted.
        load(1, 10'd12, 32'h00C0_0213);
        req_addr_v[1]  = 32'd12;
        req_valid_v[1] = 1'b1;
        load_en_v[1]   = 1'b1;
        load_addr_v[1] = 10'd12;
        load_data_v[1] = 32'h0CC0_0213;
        @(negedge clk);
        check("collide_req_ready", 1, 32'(req_ready_v[1]), 32'd0);
        step();
        load_en_v[1] = 1'b0;
        issue(1, 32'd12, 32'h0CC0_0213, 1'b0, 1);
        wait_idle(1);

        // Range boundaries.
        load(1, 10'd0, 32'h1234_5013);
        load(1, 10'h3FF, 32'h3FF0_0093);
        issue(1, 32'h3FF, 32'h3FF0_0093, 1'b0, 1);
        wait_idle(1);
`ifdef IMEM_BOUNDS_CHECK_EN
        issue(1, 32'h400, 32'h0010_0073, 1'b1, 1);
        wait_idle(1);
        issue(1, 32'h8000_0005, 32'h0010_0073, 1'b1, 1);
        wait_idle(1);
`else
        issue(1, 32'h400, 32'h1234_5013, 1'b0, 1);
        wait_idle(1);
        issue(1, 32'h8000_0005, 32'h0050_0093, 1'b0, 1);
        wait_idle(1);
`endif

        // Reset pulse two cycles after acceptance aborts the fetch.
        load(2, 10'd20, 32'h0140_0193);
        issue(2, 32'd20, 32'h0140_0193, 1'b0, 0);
        step();
        rst_v[2] = 1'b0;
        step();
        rst_v[2] = 1'b1;
        @(negedge clk);
        check("abort_resp_data", 2, resp_data_v[2], 32'h0);
        check("abort_resp_err", 2, 32'(resp_err_v[2]), 32'd0);
        check("abort_req_ready", 2, 32'(req_ready_v[2]), 32'd1);
        repeat (6) begin
            check("abort_resp_valid", 2, 32'(resp_valid_v[2]), 32'd0);
            @(negedge clk);
        end
        step();
        issue(2, 32'd20, 32'h0140_0193, 1'b0, 1);
        wait_idle(2);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
